// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states and default sizing.
package uart_pkg;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_PERIOD_W  = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/tx_timer.sv
// Bit-period timer: counts 1..rollover while enabled and strobes o_bit_tick on the
// last count of each period, then wraps back to 1.
module tx_timer
    import uart_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [PERIOD_W-1:0] i_rollover,
    output logic                o_bit_tick
);
    logic [PERIOD_W-1:0] r_cnt;
    logic                w_at_end;

    // The count never exceeds the rollover, so the maximum period cannot overflow.
    assign w_at_end   = (r_cnt == i_rollover);
    assign o_bit_tick = i_en & w_at_end;

    // Period counter with clear and wrap-to-one on the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= PERIOD_W'(1);
        end else if (i_clr) begin
            r_cnt <= PERIOD_W'(1);
        end else if (o_bit_tick) begin
            r_cnt <= PERIOD_W'(1);
        end else if (i_en) begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, with a
// per-frame programmable bit period latched at acceptance. All outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int PERIOD_W  = DEFAULT_PERIOD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [PERIOD_W-1:0]  bit_period,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_done
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        if (p == {PERIOD_W{1'b0}}) begin
            eff_period = PERIOD_W'(1);
        end else begin
            eff_period = p;
        end
    endfunction

    tx_state_t            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shift_shr;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic [PERIOD_W-1:0]  r_period, w_period_nxt;
    logic                 r_serial, w_serial_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_accept, w_tmr_en, w_bit_tick;

    // r_ready is high exactly in IDLE, so it doubles as the acceptance qualifier.
    assign w_accept    = tx_valid & r_ready;
    assign w_tmr_en    = (r_state != IDLE);
    assign w_shift_shr = r_shift >> 1;

    tx_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_tmr_en),
        .i_clr      (w_accept),
        .i_rollover (r_period),
        .o_bit_tick (w_bit_tick)
    );

    // State and datapath registers; serial_out is registered from the next-state view.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= {DATA_BITS{1'b0}};
            r_bit_idx <= {IDX_W{1'b0}};
            r_period  <= PERIOD_W'(1);
            r_serial  <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_period  <= w_period_nxt;
            r_serial  <= w_serial_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_period_nxt  = r_period;
        w_serial_nxt  = r_serial;
        w_ready_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = tx_data;
                    w_bit_idx_nxt = {IDX_W{1'b0}};
                    w_period_nxt  = eff_period(bit_period);
                    w_serial_nxt  = 1'b0;
                end else begin
                    w_serial_nxt = 1'b1;
                    w_ready_nxt  = 1'b1;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = {IDX_W{1'b0}};
                    w_serial_nxt  = r_shift[0];
                end else begin
                    w_serial_nxt = 1'b0;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt  = STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_shift_nxt   = w_shift_shr;
                        w_serial_nxt  = w_shift_shr[0];
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_serial_nxt = r_shift[0];
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_state_nxt  = IDLE;
                    w_ready_nxt  = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_serial_nxt = 1'b1;
                end else begin
                    w_serial_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_serial_nxt = 1'b1;
                w_ready_nxt  = 1'b1;
            end
        endcase
    end

    assign tx_ready   = r_ready;
    assign serial_out = r_serial;
    assign tx_done    = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted frames are queued by the driver and a line
// monitor decodes serial_out against them slot by slot.
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [13:0] bit_period;
    logic        tx_ready;
    logic        serial_out;
    logic        tx_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frames_seen = 0;
    bit mon_en      = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic [13:0] period;
        int          start_cyc;
    } exp_t;
    exp_t sb_q[$];

    uart_tx #(.DATA_BITS(8), .PERIOD_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .bit_period (bit_period),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the first start-bit cycle.
    task automatic send(input logic [7:0] d, input logic [13:0] p, input bit hold);
        int guard = 0;
        tx_data    = d;
        bit_period = p;
        tx_valid   = 1'b1;
        while (tx_ready !== 1'b1 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40000) check_eq("accept_timeout", 0, 1);
        sb_q.push_back('{data: d, period: p, start_cyc: cyc + 1});
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int g = 0;
        while (frames_seen < n && g < budget) begin
            @(negedge clk);
            g++;
        end
        check_eq("frames_done", frames_seen, n);
    endtask

    // Line monitor: decode each frame from its start edge and compare with the scoreboard.
    initial begin
        exp_t e;
        int   p, match, bad_done, bad_ready, g;
        logic exp_bit;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && serial_out === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_frame", 1, 0);
                    g = 0;
                    while (serial_out === 1'b0 && g < 200000) begin
                        @(negedge clk);
                        g++;
                    end
                end else begin
                    e = sb_q.pop_front();
                    p = (e.period == 14'd0) ? 1 : int'(e.period);
                    check_eq("start_latency", cyc, e.start_cyc);
                    bad_done  = 0;
                    bad_ready = 0;
                    for (int s = 0; s < 10; s++) begin
                        if (s == 0) exp_bit = 1'b0;
                        else if (s == 9) exp_bit = 1'b1;
                        else exp_bit = e.data[s-1];
                        match = 0;
                        for (int c = 0; c < p; c++) begin
                            if (s != 0 || c != 0) @(negedge clk);
                            if (serial_out === exp_bit) match++;
                            if (tx_done !== 1'b0) bad_done++;
                            if (tx_ready !== 1'b0) bad_ready++;
                        end
                        check_eq($sformatf("slot%0d_cycles_d%02h", s, e.data), match, p);
                    end
                    check_eq("busy_done_high", bad_done, 0);
                    check_eq("busy_ready_high", bad_ready, 0);
                    @(negedge clk);
                    check_eq("tx_done_pulse", tx_done, 1);
                    check_eq("ready_after_frame", tx_ready, 1);
                    check_eq("idle_gap_high", serial_out, 1);
                    frames_seen++;
                end
            end
        end
    end

    initial begin
        int cnt_low, cnt_done;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        bit_period = 14'd4;
        repeat (3) @(negedge clk);
        check_eq("reset_serial", serial_out, 1);
        check_eq("reset_ready", tx_ready, 1);
        check_eq("reset_done", tx_done, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        send(8'hA5, 14'd4, 1'b0);
        wait_frames(1, 200);
        send(8'h00, 14'd1, 1'b0);
        wait_frames(2, 100);
        send(8'h00, 14'd0, 1'b0);
        wait_frames(3, 100);

        send(8'h3C, 14'd2, 1'b1);
        send(8'hC3, 14'd2, 1'b0);
        wait_frames(5, 200);

        send(8'h5A, 14'd3, 1'b0);
        repeat (5) @(negedge clk);
        tx_data    = 8'hFF;
        bit_period = 14'd1;
        tx_valid   = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(6, 200);
        repeat (40) @(negedge clk);
        check_eq("no_queued_frame", sb_q.size(), 0);
        check_eq("frames_after_busy", frames_seen, 6);
        check_eq("done_low_idle", tx_done, 0);

        mon_en = 1'b0;
        send(8'hF0, 14'd4, 1'b0);
        sb_q.delete();
        repeat (17) @(negedge clk);
        check_eq("pre_reset_bit3", serial_out, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_serial", serial_out, 1);
        check_eq("midrst_ready", tx_ready, 1);
        check_eq("midrst_done", tx_done, 0);
        cnt_low  = 0;
        cnt_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) cnt_low++;
            if (tx_done !== 1'b0) cnt_done++;
        end
        check_eq("midrst_line_idle", cnt_low, 0);
        check_eq("midrst_no_done", cnt_done, 0);
        mon_en = 1'b1;
        send(8'h96, 14'd2, 1'b0);
        wait_frames(7, 100);

        @(negedge clk);
        tx_data    = 8'h81;
        bit_period = 14'd2;
        tx_valid   = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b0;
        check_eq("rstprio_ready", tx_ready, 1);
        check_eq("rstprio_serial", serial_out, 1);
        repeat (30) @(negedge clk);
        check_eq("rstprio_no_frame", frames_seen, 7);

        mon_en = 1'b0;
        send(8'h01, 14'd16383, 1'b0);
        sb_q.delete();
        cnt_low = 0;
        while (serial_out === 1'b0 && cnt_low < 20000) begin
            cnt_low++;
            @(negedge clk);
        end
        check_eq("max_start_len", cnt_low, 16383);
        check_eq("max_first_data_bit", serial_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("max_abort_ready", tx_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
